vector_rev_serializer: RTL and testbench
========================================

VECTOR_REV_SERIALIZER -- requirements
Module: vector_rev_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first, which is bit-reversed order.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_, input, WIDTH: parallel word to serialize.
REQ-006 SHALL have port in_valid, input, 1: in_ holds a word.
REQ-007 SHALL have port in_ready, output, 1: the block can accept a word this cycle.
REQ-008 SHALL have port out, output, 1: current serial bit.
REQ-009 SHALL have port out_valid, output, 1: out is valid.
REQ-010 SHALL have port out_ready, input, 1: the sink consumes out this cycle.
REQ-011 SHALL have port out_last, output, 1: out is the final bit of the word.

Function
REQ-012 SHALL implement two states: IDLE (no word held) and SHIFT (word held, bits pending).
REQ-013 SHALL accept a word on any rising edge where in_valid && in_ready.
REQ-014 SHALL, on accept, load shift register sh with in_ when MSB_FIRST=1, or with bit-reversed in_ (sh[i] = in_[WIDTH-1-i]) when MSB_FIRST=0; load bit index cnt=0; enter SHIFT.
REQ-015 SHALL drive out = sh[WIDTH-1] and out_valid = (state==SHIFT), both purely from registers.
REQ-016 SHALL drive out_last = out_valid && (cnt == WIDTH-1).
REQ-017 SHALL, on an edge with out_valid && out_ready and not out_last, shift sh left by one with zero fill and increment cnt.
REQ-018 SHALL hold sh, cnt and out stable while out_valid && !out_ready (backpressure).
REQ-019 SHALL, on an edge with out_valid && out_ready && out_last, return to IDLE unless a new word is accepted on the same edge.
REQ-020 SHALL drive in_ready = (state==IDLE) || (out_valid && out_ready && out_last); in_ready depends combinationally on out_ready only.
REQ-021 SHALL, when a word is accepted on the same edge as the last bit completes, load the new word per REQ-014 and stay in SHIFT, so words stream back-to-back with no bubble (WIDTH bits per WIDTH cycles).
REQ-022 SHALL have first-bit latency of exactly 1 cycle: the word accepted at edge T presents its first bit from edge T onward (visible in cycle T+1).
REQ-023 SHALL ignore in_ whenever no accept occurs.
REQ-024 SHALL size cnt as $clog2(WIDTH) bits and SHALL never let it exceed WIDTH-1.

Reset
REQ-025 SHALL, with rst high at an edge, set state=IDLE, sh=0 and cnt=0, overriding all other events on that edge.
REQ-026 SHALL give outputs after reset: out=0, out_valid=0, out_last=0, in_ready=1.
REQ-027 SHALL discard any in-flight word on reset mid-word, and SHALL emit no remaining bits of it after reset.

Structure
REQ-028 SHALL define the state enum typedef (IDLE, SHIFT) in the shared package vector_rev_pkg.
REQ-029 SHALL place the bit-reverse load as a function in vector_rev_pkg, reusable by a future deserializer, with no sub-module.

Verification
REQ-030 Bench SHALL check: WIDTH=8, MSB_FIRST=1, in_=8'hB1, out_ready=1 -> out = 1,0,1,1,0,0,0,1 on 8 consecutive cycles, out_last on the 8th only.
REQ-031 Bench SHALL check: MSB_FIRST=0, in_=8'hB1 -> out = 1,0,0,0,1,1,0,1; then in_=8'h01 -> out = 1,0,0,0,0,0,0,0.
REQ-032 Bench SHALL check: back-to-back 8'hB1 then 8'h0F with in_valid held -> 16 contiguous valid cycles, in_ready high only in the idle cycle and on the 8th bit.
REQ-033 Bench SHALL check: out_ready low for 3 cycles during bit 3 of 8'hB1 -> out stays 1 and cnt frozen; the stream then resumes, 8 bits total.
REQ-034 Bench SHALL check: rst asserted at bit 4 of 8'hFF -> next cycle out_valid=0 and in_ready=1; next word 8'h80 serializes cleanly.
REQ-035 Bench SHALL check: in_valid pulse while out_ready=0 mid-word -> no accept, in_ready=0, word unchanged.

Source files
------------

// File: rtl/vector_rev_pkg.sv
// Shared types and helpers for the vector serializer family.
// The bit-reverse helper is shared so a future deserializer can use it too.
package vector_rev_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int MAX_WIDTH = 32;

    // Mirrors the low w bits of v (result[i] = v[w-1-i]); bits at and above w are zero.
    function automatic logic [MAX_WIDTH-1:0] reverseBits(input logic [MAX_WIDTH-1:0] v,
                                                         input int w);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vector_rev_serializer.sv
// Parallel-to-serial converter with ready/valid on both sides.
// Words can stream back-to-back with no idle cycle between them.
module vector_rev_serializer
    import vector_rev_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam int                CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]     LAST_IDX = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_sh;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   w_loadWord;
    logic               w_accept;
    logic               w_fire;
    logic               w_isLast;

    // LSB-first is done by loading the mirrored word and always shifting out the MSB.
    generate
        if (MSB_FIRST != 0) begin : g_msbFirst
            assign w_loadWord = in_;
        end else begin : g_lsbFirst
            assign w_loadWord = WIDTH'(reverseBits(32'(in_), WIDTH));
        end
    endgenerate

    assign w_isLast = (r_state == SHIFT) && (r_cnt == LAST_IDX);
    assign w_fire   = (r_state == SHIFT) && out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (w_fire && w_isLast) begin
                    w_nextState = w_accept ? SHIFT : IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // in_ready opens on the final bit so the next word loads on the same edge.
    always_comb begin
        out_valid = (r_state == SHIFT);
        out       = r_sh[WIDTH-1];
        out_last  = w_isLast;
        in_ready  = (r_state == IDLE) || (w_fire && w_isLast);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_sh  <= w_loadWord;
            r_cnt <= '0;
        end else if (w_fire && !w_isLast) begin
            r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_vector_rev_serializer.sv
// Bench for vector_rev_serializer: one MSB-first and one LSB-first instance,
// with a bit-level scoreboard fed on accept and drained on each serial beat.
module tb_vector_rev_serializer;

    typedef struct {
        logic b;
        logic last;
    } beat_t;

    logic       clk;
    logic       rst;

    logic [7:0] mIn, lIn;
    logic       mInValid, lInValid;
    logic       mOutReady, lOutReady;
    logic       mInReady, lInReady;
    logic       mOut, lOut;
    logic       mOutValid, lOutValid;
    logic       mOutLast, lOutLast;

    beat_t      qM[$];
    beat_t      qL[$];

    int         total = 0;
    int         bad   = 0;

    vector_rev_serializer #(.WIDTH(8), .MSB_FIRST(1)) dutM (
        .clk(clk), .rst(rst),
        .in_(mIn), .in_valid(mInValid), .in_ready(mInReady),
        .out(mOut), .out_valid(mOutValid), .out_ready(mOutReady), .out_last(mOutLast)
    );

    vector_rev_serializer #(.WIDTH(8), .MSB_FIRST(0)) dutL (
        .clk(clk), .rst(rst),
        .in_(lIn), .in_valid(lInValid), .in_ready(lInReady),
        .out(lOut), .out_valid(lOutValid), .out_ready(lOutReady), .out_last(lOutLast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit lsbDut, input logic [7:0] data, input logic valid);
        if (lsbDut) begin
            lIn      = data;
            lInValid = valid;
        end else begin
            mIn      = data;
            mInValid = valid;
        end
    endtask

    // Scoreboard model, sampled mid-cycle when inputs and outputs are stable.
    always @(negedge clk) begin
        logic expValid;
        logic expReady;
        if (rst) begin
            qM.delete();
            qL.delete();
        end else begin
            expValid = (qM.size() > 0);
            expReady = !expValid || (mOutReady && qM[0].last);
            checkOutput("m_out_valid", 32'(mOutValid), 32'(expValid));
            checkOutput("m_in_ready", 32'(mInReady), 32'(expReady));
            if (expValid) begin
                checkOutput("m_out", 32'(mOut), 32'(qM[0].b));
                checkOutput("m_out_last", 32'(mOutLast), 32'(qM[0].last));
                if (mOutReady) void'(qM.pop_front());
            end else begin
                checkOutput("m_out_last_idle", 32'(mOutLast), 32'd0);
            end
            if (mInValid && expReady) begin
                for (int i = 7; i >= 0; i--) qM.push_back('{b: mIn[i], last: (i == 0)});
            end

            expValid = (qL.size() > 0);
            expReady = !expValid || (lOutReady && qL[0].last);
            checkOutput("l_out_valid", 32'(lOutValid), 32'(expValid));
            checkOutput("l_in_ready", 32'(lInReady), 32'(expReady));
            if (expValid) begin
                checkOutput("l_out", 32'(lOut), 32'(qL[0].b));
                checkOutput("l_out_last", 32'(lOutLast), 32'(qL[0].last));
                if (lOutReady) void'(qL.pop_front());
            end
            if (lInValid && expReady) begin
                for (int i = 0; i < 8; i++) qL.push_back('{b: lIn[i], last: (i == 7)});
            end
        end
    end

    initial begin
        logic [7:0] seqM;
        rst       = 1'b1;
        mIn       = 8'h00;  lIn       = 8'h00;
        mInValid  = 1'b0;   lInValid  = 1'b0;
        mOutReady = 1'b1;   lOutReady = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("rst_m_out", 32'(mOut), 32'd0);
        checkOutput("rst_m_out_valid", 32'(mOutValid), 32'd0);
        checkOutput("rst_m_out_last", 32'(mOutLast), 32'd0);
        checkOutput("rst_m_in_ready", 32'(mInReady), 32'd1);
        checkOutput("rst_l_out_valid", 32'(lOutValid), 32'd0);
        checkOutput("rst_l_in_ready", 32'(lInReady), 32'd1);

        // MSB-first B1: capture the serial stream directly as well.
        applyStimulus(1'b0, 8'hB1, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        seqM = 8'h00;
        for (int i = 0; i < 8; i++) begin
            seqM = {seqM[6:0], mOut};
            checkOutput("b1_msb_valid", 32'(mOutValid), 32'd1);
            checkOutput("b1_msb_last", 32'(mOutLast), 32'(i == 7));
            tick();
        end
        checkOutput("b1_msb_seq", 32'(seqM), 32'hB1);
        checkOutput("b1_msb_done", 32'(mOutValid), 32'd0);

        // LSB-first B1 then 01.
        applyStimulus(1'b1, 8'hB1, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0);
        seqM = 8'h00;
        for (int i = 0; i < 8; i++) begin
            seqM = {seqM[6:0], lOut};
            tick();
        end
        checkOutput("b1_lsb_seq", 32'(seqM), 32'h8D);
        applyStimulus(1'b1, 8'h01, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0);
        seqM = 8'h00;
        for (int i = 0; i < 8; i++) begin
            seqM = {seqM[6:0], lOut};
            tick();
        end
        checkOutput("01_lsb_seq", 32'(seqM), 32'h80);

        // Back-to-back B1 then 0F with in_valid held throughout.
        applyStimulus(1'b0, 8'hB1, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h0F, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("b2b_ready_w1", 32'(mInReady), 32'(i == 7));
            checkOutput("b2b_valid_w1", 32'(mOutValid), 32'd1);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("b2b_valid_w2", 32'(mOutValid), 32'd1);
            tick();
        end
        checkOutput("b2b_idle_after", 32'(mOutValid), 32'd0);

        // Backpressure on bit index 3 of B1, with an ignored in_valid pulse.
        applyStimulus(1'b0, 8'hB1, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick(); tick(); tick();
        mOutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) applyStimulus(1'b0, 8'h55, 1'b1);
            checkOutput("bp_hold_out", 32'(mOut), 32'd1);
            checkOutput("bp_hold_last", 32'(mOutLast), 32'd0);
            checkOutput("bp_in_ready", 32'(mInReady), 32'd0);
            tick();
            applyStimulus(1'b0, 8'h00, 1'b0);
        end
        mOutReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_resume_valid", 32'(mOutValid), 32'd1);
            tick();
        end
        checkOutput("bp_done", 32'(mOutValid), 32'd0);

        // Reset in the middle of FF, then a clean 80.
        applyStimulus(1'b0, 8'hFF, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_valid", 32'(mOutValid), 32'd0);
        checkOutput("mid_rst_ready", 32'(mInReady), 32'd1);
        checkOutput("mid_rst_out", 32'(mOut), 32'd0);
        tick();
        checkOutput("mid_rst_stays_idle", 32'(mOutValid), 32'd0);
        applyStimulus(1'b0, 8'h80, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        seqM = 8'h00;
        for (int i = 0; i < 8; i++) begin
            seqM = {seqM[6:0], mOut};
            tick();
        end
        checkOutput("post_rst_80_seq", 32'(seqM), 32'h80);

        tick(); tick();
        checkOutput("drain_m", 32'(qM.size()), 32'd0);
        checkOutput("drain_l", 32'(qL.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
